cordic_rotation_engine: RTL and testbench
=========================================

CORDIC_ROTATION_ENGINE -- requirements
Module: cordic_rotation_engine

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 x_in  input  14  signed S1.12 initial X.
REQ-006 y_in  input  14  signed S1.12 initial Y.
REQ-007 theta_in  input  14  signed S1.12 rotation angle in radians; legal range -6434..+6434 (±pi/2).
REQ-008 x_out  output  14  signed S1.12 rotated X, registered.
REQ-009 y_out  output  14  signed S1.12 rotated Y, registered.
REQ-010 z_out  output  14  signed S1.12 residual angle, registered.
REQ-011 busy  output  1  high while iterating.
REQ-012 done  output  1  one-cycle pulse when results are valid.

Function
REQ-013 The block SHALL be an iterative rotation-mode CORDIC: it drives the angle accumulator z toward zero, which is the inverse of vectoring mode.
REQ-014 FSM: IDLE and ROT only.
REQ-015 IDLE with start=1 at a clock edge (edge 0) SHALL load x<=x_in, y<=y_in, z<=theta_in, i<=0, set busy=1 and go to ROT.
REQ-016 Each ROT edge SHALL perform one iteration i:
- If z[13]==0: x<=x-(y>>>i), y<=y+(x>>>i), z<=z-A[i].
- Otherwise: x<=x+(y>>>i), y<=y-(x>>>i), z<=z+A[i].
- Both updates SHALL use the pre-edge x and y.
REQ-017 Shifts SHALL be arithmetic; all adds SHALL be 14-bit two's complement with wrap and no saturation.
REQ-018 A[0..11] SHALL be the constants 3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2 (atan(2^-i) in S1.12).
REQ-019 Exactly 12 iterations SHALL run, on edges 1..12.
REQ-020 At edge 12 the block SHALL:
- load x_out, y_out and z_out with the final x, y and z;
- set done=1 for exactly one cycle;
- clear busy;
- return to IDLE.
REQ-021 Latency SHALL be 12 cycles from the start edge to done high. A new start is accepted no earlier than edge 13, giving a throughput of one result per 13 cycles.
REQ-022 start while busy=1 SHALL be ignored and SHALL have no effect on the running operation.
REQ-023 x_out, y_out and z_out SHALL hold their values until the next completion. They SHALL NOT change during a subsequent ROT.
REQ-024 Outputs SHALL carry CORDIC gain 1.6468.
- The caller pre-scales: x_in=2487 (K), y_in=0 yields cos/sin.
- The caller SHALL keep |(x_in,y_in)| <= 1.2 (4915) so that no overflow occurs.
REQ-025 Inputs x_in, y_in and theta_in SHALL be sampled only at the start edge, and MAY change afterward.

Reset
REQ-026 While rst_n=0, regardless of clk:
- the FSM SHALL be IDLE;
- busy=0, done=0;
- x_out=y_out=z_out=0;
- internal x, y, z and i SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-028 After rst_n deasserts, the first edge with start=1 SHALL begin a new operation normally.

Verification
REQ-029 x_in=2487, y_in=0, theta_in=0, start pulse:
- done exactly 12 cycles later;
- x_out=4096±4, y_out=0±4, |z_out|<=4.
REQ-030 x_in=2487, y_in=0, theta_in=3217 (pi/4): x_out=2896±4, y_out=2896±4.
REQ-031 x_in=2487, y_in=0, theta_in=-6434 (-pi/2): x_out=0±4, y_out=-4096±4.
REQ-032 Start, then start held high for the next 11 cycles with different inputs:
- exactly one done, at cycle 12;
- results match the first inputs;
- busy stays high for cycles 0..11.
REQ-033 rst_n pulsed low at iteration 6:
- busy=0 and outputs=0 immediately;
- no done;
- a subsequent start completes correctly.
REQ-034 Back-to-back operations with start asserted continuously: done at cycles 12, 25 and 38, with x_out/y_out stable between done pulses.

Source files
------------

// File: rtl/cordic_rotation_engine.sv
// Iterative rotation-mode CORDIC: 12 shift-add iterations drive the angle z to zero
// and rotate (x, y) by theta. The result carries the CORDIC gain of about 1.6468.
module cordic_rotation_engine (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [13:0] x_in,
    input  logic signed [13:0] y_in,
    input  logic signed [13:0] theta_in,
    output logic signed [13:0] x_out,
    output logic signed [13:0] y_out,
    output logic signed [13:0] z_out,
    output logic               busy,
    output logic               done,
    output logic               dbg_state
);

    // Handshake: start is sampled only while idle (busy=0); busy stays high for the
    // 12 iteration cycles and done pulses for one cycle as the outputs update.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ROT  = 1'b1;

    logic [0:0]         r_state;
    logic signed [13:0] r_x;
    logic signed [13:0] r_y;
    logic signed [13:0] r_z;
    logic [3:0]         r_i;
    logic signed [13:0] r_x_out;
    logic signed [13:0] r_y_out;
    logic signed [13:0] r_z_out;
    logic               r_busy;
    logic               r_done;

    logic signed [13:0] w_angle;
    logic signed [13:0] w_x_sh;
    logic signed [13:0] w_y_sh;
    logic signed [13:0] w_x_nxt;
    logic signed [13:0] w_y_nxt;
    logic signed [13:0] w_z_nxt;

    // atan(2^-i) in S1.12
    always_comb begin
        w_angle = 14'sd0;
        case (r_i)
            4'd0:  w_angle = 14'sd3217;
            4'd1:  w_angle = 14'sd1899;
            4'd2:  w_angle = 14'sd1003;
            4'd3:  w_angle = 14'sd509;
            4'd4:  w_angle = 14'sd256;
            4'd5:  w_angle = 14'sd128;
            4'd6:  w_angle = 14'sd64;
            4'd7:  w_angle = 14'sd32;
            4'd8:  w_angle = 14'sd16;
            4'd9:  w_angle = 14'sd8;
            4'd10: w_angle = 14'sd4;
            4'd11: w_angle = 14'sd2;
            default: w_angle = 14'sd0;
        endcase
    end

    always_comb begin
        w_x_sh = r_x >>> r_i;
        w_y_sh = r_y >>> r_i;
        if (!r_z[13]) begin
            w_x_nxt = r_x - w_y_sh;
            w_y_nxt = r_y + w_x_sh;
            w_z_nxt = r_z - w_angle;
        end else begin
            w_x_nxt = r_x + w_y_sh;
            w_y_nxt = r_y - w_x_sh;
            w_z_nxt = r_z + w_angle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_i     <= '0;
            r_x_out <= '0;
            r_y_out <= '0;
            r_z_out <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_x     <= x_in;
                        r_y     <= y_in;
                        r_z     <= theta_in;
                        r_i     <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ROT;
                    end
                end
                ST_ROT: begin
                    r_x <= w_x_nxt;
                    r_y <= w_y_nxt;
                    r_z <= w_z_nxt;
                    if (r_i == 4'd11) begin
                        // Last iteration result goes straight to the output registers.
                        r_x_out <= w_x_nxt;
                        r_y_out <= w_y_nxt;
                        r_z_out <= w_z_nxt;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_i     <= 4'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_i <= r_i + 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign x_out     = r_x_out;
    assign y_out     = r_y_out;
    assign z_out     = r_z_out;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cordic_rotation_engine.sv
// Bench for cordic_rotation_engine: directed angle vectors with tolerance checks plus
// randomized operations scored against an integer CORDIC reference model.
module tb_cordic_rotation_engine;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [13:0] x_in;
    logic signed [13:0] y_in;
    logic signed [13:0] theta_in;
    logic signed [13:0] x_out;
    logic signed [13:0] y_out;
    logic signed [13:0] z_out;
    logic               busy;
    logic               done;
    logic               dbg_state;

    int pass_cnt;
    int total_cnt;
    logic [41:0] exp_q[$];

    localparam int A_TBL[12] = '{3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2};

    cordic_rotation_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_in(x_in), .y_in(y_in), .theta_in(theta_in),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wrap14(input int v);
        int r;
        r = v & 16383;
        if (r >= 8192) r = r - 16384;
        return r;
    endfunction

    // Reference: 12 rotation-mode iterations on wrapped 14-bit integers.
    function automatic logic [41:0] model(input int x0, input int y0, input int t0);
        int x, y, z, xn, yn;
        x = wrap14(x0); y = wrap14(y0); z = wrap14(t0);
        for (int i = 0; i < 12; i++) begin
            if (z >= 0) begin
                xn = x - (y >>> i); yn = y + (x >>> i); z = z - A_TBL[i];
            end else begin
                xn = x + (y >>> i); yn = y - (x >>> i); z = z + A_TBL[i];
            end
            x = wrap14(xn); y = wrap14(yn); z = wrap14(z);
        end
        return {x[13:0], y[13:0], z[13:0]};
    endfunction

    function automatic int rnd_xy();
        return int'($urandom_range(6800)) - 3400;
    endfunction

    function automatic int rnd_t();
        return int'($urandom_range(12868)) - 6434;
    endfunction

    // driver: start edge happens between the two negedges; returns at cycle 0
    task automatic start_op(input int x, input int y, input int t);
        @(negedge clk);
        x_in = 14'(x); y_in = 14'(y); theta_in = 14'(t); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x_in = 14'(rnd_xy()); y_in = 14'(rnd_xy()); theta_in = 14'(rnd_t());
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; x_in = '0; y_in = '0; theta_in = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({x_out, y_out, z_out, busy, done, dbg_state} !== 45'd0)
            $display("FAIL reset_state got x=%0d y=%0d z=%0d busy=%b done=%b st=%b want all 0",
                     x_out, y_out, z_out, busy, done, dbg_state);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
    endtask

    task automatic test_directed;
        int tv[3] = '{0, 3217, -6434};
        int ex[3] = '{4096, 2896, 0};
        int ey[3] = '{0, 2896, -4096};
        int cyc, ax, ay, az;
        logic [41:0] exp;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(model(2487, 0, tv[k]));
            start_op(2487, 0, tv[k]);
            wait_done(cyc);
            total_cnt++;
            if (cyc !== 12) $display("FAIL dir%0d_latency got %0d want 12", k, cyc);
            else pass_cnt++;
            ax = x_out; ay = y_out; az = z_out;
            total_cnt++;
            if (ax - ex[k] > 4 || ex[k] - ax > 4 || ay - ey[k] > 4 || ey[k] - ay > 4)
                $display("FAIL dir%0d_xy got x=%0d y=%0d want x=%0d y=%0d (+-4)",
                         k, ax, ay, ex[k], ey[k]);
            else pass_cnt++;
            if (k == 0) begin
                total_cnt++;
                if (az > 4 || az < -4) $display("FAIL dir0_z got %0d want |z|<=4", az);
                else pass_cnt++;
            end
            exp = exp_q.pop_front();
            total_cnt++;
            if ({x_out, y_out, z_out} !== exp)
                $display("FAIL dir%0d_exact got %h want %h", k, {x_out, y_out, z_out}, exp);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if (done !== 1'b0) $display("FAIL dir%0d_done_width got done=%b want 0", k, done);
            else pass_cnt++;
        end
    endtask

    task automatic test_random;
        int cyc, x, y, t;
        logic [41:0] exp;
        for (int k = 0; k < 20; k++) begin
            x = rnd_xy(); y = rnd_xy(); t = rnd_t();
            exp_q.push_back(model(x, y, t));
            start_op(x, y, t);
            total_cnt++;
            if (busy !== 1'b1) $display("FAIL rnd%0d_busy got %b want 1", k, busy);
            else pass_cnt++;
            wait_done(cyc);
            total_cnt++;
            if (cyc !== 12) $display("FAIL rnd%0d_latency got %0d want 12", k, cyc);
            else pass_cnt++;
            exp = exp_q.pop_front();
            total_cnt++;
            if ({x_out, y_out, z_out} !== exp)
                $display("FAIL rnd%0d_result in=(%0d,%0d,%0d) got %h want %h",
                         k, x, y, t, {x_out, y_out, z_out}, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_ignored;
        int x, y, t, dcnt, bad_busy;
        logic [41:0] exp;
        x = rnd_xy(); y = rnd_xy(); t = rnd_t();
        exp_q.push_back(model(x, y, t));
        @(negedge clk);
        x_in = 14'(x); y_in = 14'(y); theta_in = 14'(t); start = 1'b1;
        dcnt = 0; bad_busy = 0;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) bad_busy++;
            if (done === 1'b1) dcnt++;
            x_in = 14'(rnd_xy()); y_in = 14'(rnd_xy()); theta_in = 14'(rnd_t());
            start = (c < 11);
        end
        total_cnt++;
        if (bad_busy !== 0) $display("FAIL hold_busy got %0d low cycles want 0", bad_busy);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b1 || dcnt !== 0)
            $display("FAIL hold_done_c12 got done=%b early=%0d want 1 0", done, dcnt);
        else pass_cnt++;
        exp = exp_q.pop_front();
        total_cnt++;
        if ({x_out, y_out, z_out} !== exp)
            $display("FAIL hold_result got %h want %h", {x_out, y_out, z_out}, exp);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL hold_after got done=%b busy=%b want 0 0", done, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int dcnt, cyc, x, y, t;
        logic [41:0] exp;
        start_op(rnd_xy(), rnd_xy(), rnd_t());
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({x_out, y_out, z_out, busy, done} !== 44'd0)
            $display("FAIL midrst_clear got x=%0d y=%0d z=%0d busy=%b done=%b want 0",
                     x_out, y_out, z_out, busy, done);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        total_cnt++;
        if (dcnt !== 0) $display("FAIL midrst_no_done got %0d pulses want 0", dcnt);
        else pass_cnt++;
        x = rnd_xy(); y = rnd_xy(); t = rnd_t();
        exp_q.push_back(model(x, y, t));
        start_op(x, y, t);
        wait_done(cyc);
        exp = exp_q.pop_front();
        total_cnt++;
        if (cyc !== 12 || {x_out, y_out, z_out} !== exp)
            $display("FAIL midrst_restart got cyc=%0d res=%h want cyc=12 res=%h",
                     cyc, {x_out, y_out, z_out}, exp);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int ox[3], oy[3], ot[3];
        int k;
        logic want;
        logic [13:0] lx, ly;
        logic [41:0] exp;
        for (int i = 0; i < 3; i++) begin
            ox[i] = rnd_xy(); oy[i] = rnd_xy(); ot[i] = rnd_t();
        end
        @(negedge clk);
        x_in = 14'(ox[0]); y_in = 14'(oy[0]); theta_in = 14'(ot[0]); start = 1'b1;
        exp_q.push_back(model(ox[0], oy[0], ot[0]));
        lx = x_out; ly = y_out; k = 0;
        for (int c = 0; c <= 38; c++) begin
            @(negedge clk);
            want = (c == 12 || c == 25 || c == 38);
            total_cnt++;
            if (done !== want) $display("FAIL b2b_done_c%0d got %b want %b", c, done, want);
            else pass_cnt++;
            if (done === 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 42'd0;
                total_cnt++;
                if ({x_out, y_out, z_out} !== exp)
                    $display("FAIL b2b_result_c%0d got %h want %h", c, {x_out, y_out, z_out}, exp);
                else pass_cnt++;
                lx = x_out; ly = y_out; k++;
                if (k < 3) begin
                    x_in = 14'(ox[k]); y_in = 14'(oy[k]); theta_in = 14'(ot[k]);
                    exp_q.push_back(model(ox[k], oy[k], ot[k]));
                end
            end else begin
                if (x_out !== lx || y_out !== ly) begin
                    total_cnt++;
                    $display("FAIL b2b_stable_c%0d got x=%0d y=%0d want x=%0d y=%0d",
                             c, x_out, y_out, lx, ly);
                end
                x_in = 14'(rnd_xy()); y_in = 14'(rnd_xy()); theta_in = 14'(rnd_t());
            end
        end
        start = 1'b0;
        total_cnt++;
        if (k !== 3) $display("FAIL b2b_count got %0d want 3", k);
        else pass_cnt++;
        exp_q.delete();
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
